mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port and its load/store port.
- Serialises accesses, drives the memory handshake, and returns read data and a done pulse to each requester.
- Provides a stall signal so the core can hold PC and the register-file write while an access is outstanding.
- Sits between Top's datapath and the instruction/data memory; this is the step from a single-cycle core to a multi-cycle shared-memory core.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- DATA_W, 32, data width; DATA_W/8 byte strobes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_done.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  DATA_W  fetched instruction; valid when if_done.
- if_done  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wstrb  in  DATA_W/8  byte enables for stores.
- d_rdata  out  DATA_W  load data; valid when d_done.
- d_done  out  1  one-cycle completion pulse for data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wstrb  out  DATA_W/8  memory byte enables; 0 on reads.
- mem_ready  in  1  memory completes the access presented on the current edge.
- mem_rdata  in  DATA_W  read data; valid with mem_ready.
- stall  out  1  combinational: (if_req & ~if_done) | (d_req & ~d_done).

Behaviour:
- All mem_* and *_rdata/*_done outputs are registered.
- Reset (async, rst=1): state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, if_rdata=0, d_rdata=0, if_done=0, d_done=0, last_grant=IF.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - A requester is eligible if its req=1 and its done=0 in this cycle, so a requester dropping req during its done pulse is never re-issued.
  - If both are eligible: grant data when last_grant=IF, else grant fetch (alternating fairness).
  - If only one is eligible, grant it.
  - On grant at edge N: latch addr, we, wdata and wstrb into the mem_* registers; set mem_req=1; go to BUSY_I or BUSY_D; update last_grant.
  - A fetch grant forces mem_we=0 and mem_wstrb=0.
- BUSY_x: mem_* held stable until an edge with mem_ready=1. At that edge:
  - capture mem_rdata into x_rdata (loads and fetches only; on stores x_rdata is unchanged);
  - set x_done=1 for exactly one cycle;
  - mem_req=0; return to IDLE.
- Minimum access period: grant at edge N, completion at edge N+1, done high during cycle N+1, next grant no earlier than edge N+2. Earliest throughput is one access per two cycles.
- mem_ready while mem_req=0 is ignored.
- Requester changes to addr/data during BUSY are ignored; the latched values are used.
- rst asserted mid-access aborts the access immediately: all outputs go to reset values and no done pulse is issued.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - Parameter TIMEOUT (default 255) and output bus_err (1 bit, registered, reset 0) are added.
  - A counter clears on each grant and increments every BUSY cycle.
  - If it reaches TIMEOUT without mem_ready: the pending done pulses with rdata = all-ones, bus_err pulses for one cycle, mem_req drops, and the FSM returns to IDLE.
- When undefined: no counter and no port; BUSY waits indefinitely.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum {IDLE, BUSY_I, BUSY_D};
  - the grant enum {GNT_IF, GNT_D};
  - default ADDR_W/DATA_W constants;
  - TIMEOUT_DEFAULT.
- One natural sub-module, arb_pick: combinational two-way fair pick taking eligible_if, eligible_d and last_grant, producing grant_valid and grant_id.
- Everything else stays in mem_port_arbiter.

Test Plan:
- Reset then single fetch: if_req=1, if_addr=0x00000004, memory ready after 1 cycle with rdata 0x00500093 -> mem_addr=0x4 with mem_we=0; if_done pulses once with if_rdata=0x00500093; stall low the following cycle.
- Simultaneous requests after reset: if_req and d_req (load, addr 0x100) high on the same edge -> data granted first (last_grant=IF); fetch granted on the next IDLE edge; two done pulses, in order d then if.
- Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0b0011, mem_ready delayed 3 cycles -> mem_* stable for 4 cycles; d_done pulses once; d_rdata unchanged.
- Continuous contention over 6 accesses -> grants alternate D,I,D,I,D,I; no requester waits more than one other access.
- rst pulsed during BUSY_D with mem_ready still low -> mem_req drops asynchronously; no d_done; after release, re-presented d_req completes normally.
- With ARB_TIMEOUT_EN and TIMEOUT=4, mem_ready held low -> after 4 BUSY cycles d_done=1, d_rdata=0xFFFFFFFF, bus_err pulses for 1 cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory handshake signals around the arbiter.
// bus_err exists only when ARB_TIMEOUT_EN is defined.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_done;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_done;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_ready;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  stall;
`ifdef ARB_TIMEOUT_EN
    logic                  bus_err;
`endif

    // Arbiter side: serves the requesters and drives the memory.
    modport master (
`ifdef ARB_TIMEOUT_EN
        output bus_err,
`endif
        input  if_req, if_addr,
        output if_rdata, if_done,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        output stall
    );

    // Environment side: core requesters plus the memory itself.
    modport slave (
`ifdef ARB_TIMEOUT_EN
        input  bus_err,
`endif
        output if_req, if_addr,
        input  if_rdata, if_done,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        input  stall
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Two-way fair pick: on contention the port that did not win last time is chosen.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   eligible_if,
    input  logic   eligible_d,
    input  grant_t last_grant,
    output logic   grant_valid,
    output grant_t grant_id
);

    always_comb begin
        grant_valid = eligible_if | eligible_d;
        grant_id    = GNT_IF;
        if (eligible_if && eligible_d) begin
            grant_id = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
        end else if (eligible_d) begin
            grant_id = GNT_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and load/store onto one single-port memory.
// Define ARB_TIMEOUT_EN to add a BUSY watchdog (TIMEOUT parameter, bus_err pulse).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
`ifdef ARB_TIMEOUT_EN
   ,parameter int TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    // state  | meaning
    // IDLE   | no access outstanding, arbitrate this cycle
    // BUSY_I | fetch presented to memory, waiting for mem_ready
    // BUSY_D | load/store presented to memory, waiting for mem_ready

    localparam int STRB_W = DATA_W / 8;

    state_t              state_q, state_d;
    grant_t              last_grant_q, last_grant_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_done_q, if_done_d;
    logic                d_done_q, d_done_d;

    logic                eligible_if, eligible_d;
    logic                grant_valid;
    grant_t              grant_id;
    logic                finish;
    logic                timed_out;
    logic [DATA_W-1:0]   rsp;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                bus_err_q, bus_err_d;
`endif

    // A requester still showing its done pulse is finishing, not asking again.
    assign eligible_if = bus.if_req & ~if_done_q;
    assign eligible_d  = bus.d_req  & ~d_done_q;

    arb_pick u_pick (
        .eligible_if (eligible_if),
        .eligible_d  (eligible_d),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        finish       = 1'b0;
        timed_out    = 1'b0;
        rsp          = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        bus_err_d    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    mem_req_d    = 1'b1;
                    last_grant_d = grant_id;
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    if (grant_id == GNT_D) begin
                        state_d     = BUSY_D;
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_wstrb_d = bus.d_we ? bus.d_wstrb : '0;
                    end else begin
                        state_d     = BUSY_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    finish = 1'b1;
                    rsp    = bus.mem_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                    rsp       = '1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            mem_req_d = 1'b0;
            state_d   = IDLE;
            if (state_q == BUSY_I) begin
                if_done_d  = 1'b1;
                if_rdata_d = rsp;
            end else begin
                d_done_d = 1'b1;
                // Stores leave the load-data register untouched unless the access failed.
                if (!mem_we_q || timed_out) begin
                    d_rdata_d = rsp;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.bus_err = bus_err_q;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.stall     = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed table, corner sequences, randomized traffic vs. a memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_TIMEOUT_EN
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name);
        int n;
        n = 0;
        while (!bus.mem_req && n < 10) begin
            tick();
            n++;
        end
        chk1(name, bus.mem_req, 1'b1);
    endtask

    // Grant monitor: the two requesters use disjoint address regions (bit 8 set = data).
    logic req_prev = 1'b0;
    int   gcnt_i = 0;
    int   gcnt_d = 0;
    always @(negedge clk) begin
        if (bus.mem_req && !req_prev) begin
            if (bus.mem_addr[8]) gcnt_d++;
            else                 gcnt_i++;
        end
        req_prev = bus.mem_req;
    end

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h0BAD_0000 ^ (a * 32'h9E37_79B1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    logic [31:0] mem_arr [16];
    logic [31:0] ref_mem [16];
    logic [31:0] model_d_rdata;
    bit          fin_i, fin_d;

    task automatic fetch_thread(input int n);
        logic [31:0] a;
        int          s_own, s_oth;
        bit          got;
        for (int k = 0; k < n; k++) begin
            a = 32'($urandom_range(15)) * 4;
            bus.if_addr = a;
            s_own = gcnt_i;
            s_oth = gcnt_d;
            bus.if_req = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (bus.if_done) begin got = 1'b1; break; end
            end
            bus.if_req = 1'b0;
            chk1("rand_if_done_seen", got, 1'b1);
            if (!got) break;
            chk32("rand_if_rdata", bus.if_rdata, rom(a));
            chk1("rand_if_wait_bound", (gcnt_d - s_oth) <= 1, 1'b1);
            chk32("rand_if_issued_once", 32'(gcnt_i - s_own), 32'd1);
            repeat ($urandom_range(2)) tick();
        end
        fin_i = 1'b1;
    endtask

    task automatic data_thread(input int n);
        int          idx, s_own, s_oth;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  strb;
        bit          got;
        for (int k = 0; k < n; k++) begin
            idx  = $urandom_range(15);
            we   = 1'($urandom_range(1));
            wd   = $urandom;
            strb = 4'($urandom_range(15));
            bus.d_addr  = 32'h100 + 32'(idx) * 4;
            bus.d_we    = we;
            bus.d_wdata = wd;
            bus.d_wstrb = strb;
            if (we) ref_mem[idx] = merge(ref_mem[idx], wd, strb);
            else    model_d_rdata = ref_mem[idx];
            s_own = gcnt_d;
            s_oth = gcnt_i;
            bus.d_req = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 100; c++) begin
                tick();
                if (bus.d_done) begin got = 1'b1; break; end
            end
            bus.d_req = 1'b0;
            chk1("rand_d_done_seen", got, 1'b1);
            if (!got) break;
            chk32("rand_d_rdata", bus.d_rdata, model_d_rdata);
            chk1("rand_d_wait_bound", (gcnt_i - s_oth) <= 1, 1'b1);
            chk32("rand_d_issued_once", 32'(gcnt_d - s_own), 32'd1);
            repeat ($urandom_range(2)) tick();
        end
        fin_d = 1'b1;
    endtask

    // Memory with a random 0..3 cycle response latency.
    task automatic responder();
        int          w;
        logic [31:0] a;
        w = $urandom_range(3);
        while (!(fin_i && fin_d)) begin
            tick();
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (bus.mem_req) begin
                if (w == 0) begin
                    a = bus.mem_addr;
                    if (bus.mem_we) begin
                        if (a[8]) mem_arr[a[5:2]] = merge(mem_arr[a[5:2]], bus.mem_wdata, bus.mem_wstrb);
                        bus.mem_rdata = $urandom;
                    end else begin
                        bus.mem_rdata = a[8] ? mem_arr[a[5:2]] : rom(a);
                    end
                    bus.mem_ready = 1'b1;
                    w = $urandom_range(3);
                end else begin
                    w--;
                end
            end
        end
        bus.mem_ready = 1'b0;
    endtask

    typedef struct {
        bit          drive_if;
        logic [31:0] if_addr;
        bit          drive_d;
        bit          d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_wstrb;
        int          delay;
        logic [31:0] resp;
        bit          exp_d;
        logic [31:0] exp_addr;
        bit          exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl [NV];

    initial begin
        string nm;
        int    n;

        tbl[0] = '{1, 32'h4,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h0050_0093, 0, 32'h4,   0, 4'h0, 32'h0,        32'h0050_0093};
        tbl[1] = '{1, 32'h8,  1, 0, 32'h100, 32'hCAFE_F00D, 4'hF, 0, 32'h1111_1111, 1, 32'h100, 0, 4'h0, 32'h0,        32'h1111_1111};
        tbl[2] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 1, 32'h2222_2222, 0, 32'h8,   0, 4'h0, 32'h0,        32'h2222_2222};
        tbl[3] = '{0, 32'h0,  1, 1, 32'h200, 32'hDEAD_BEEF, 4'h3, 3, 32'h9999_9999, 1, 32'h200, 1, 4'h3, 32'hDEAD_BEEF, 32'h1111_1111};
        tbl[4] = '{1, 32'hC,  1, 1, 32'h204, 32'h1234_5678, 4'hF, 1, 32'h3333_3333, 0, 32'hC,   0, 4'h0, 32'h0,        32'h3333_3333};
        tbl[5] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h4444_4444, 1, 32'h204, 1, 4'hF, 32'h1234_5678, 32'h1111_1111};
        tbl[6] = '{1, 32'h10, 1, 0, 32'h104, 32'h0,        4'hF, 2, 32'h5555_5555, 0, 32'h10,  0, 4'h0, 32'h0,        32'h5555_5555};
        tbl[7] = '{0, 32'h0,  0, 0, 32'h0,   32'h0,        4'h0, 0, 32'h6666_6666, 1, 32'h104, 0, 4'h0, 32'h0,        32'h6666_6666};
        tbl[8] = '{0, 32'h0,  1, 0, 32'h108, 32'h0,        4'h0, 0, 32'h7777_7777, 1, 32'h108, 0, 4'h0, 32'h0,        32'h7777_7777};

        bus.if_req = 1'b0;  bus.if_addr = '0;
        bus.d_req = 1'b0;   bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        fin_i = 1'b0; fin_d = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk1 ("rst_mem_req",   bus.mem_req,   1'b0);
        chk1 ("rst_mem_we",    bus.mem_we,    1'b0);
        chk32("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk32("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
        chk32("rst_if_rdata",  bus.if_rdata,  32'h0);
        chk32("rst_d_rdata",   bus.d_rdata,   32'h0);
        chk1 ("rst_if_done",   bus.if_done,   1'b0);
        chk1 ("rst_d_done",    bus.d_done,    1'b0);
        chk1 ("rst_stall",     bus.stall,     1'b0);
        tick();
        rst = 1'b0;

        // Continuous contention from reset: grants alternate D,I,D,I,D,I
        bus.if_addr = 32'h20;
        bus.d_addr  = 32'h120;
        bus.d_we    = 1'b0;
        bus.if_req  = 1'b1;
        bus.d_req   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_grant($sformatf("cont%0d_grant", k));
            chk1($sformatf("cont%0d_is_data", k), bus.mem_addr[8], (k % 2) == 0);
            bus.mem_rdata = 32'hC0DE_0000 + 32'(k);
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            if (k == 5) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
            if ((k % 2) == 0) begin
                chk1 ($sformatf("cont%0d_d_done", k), bus.d_done, 1'b1);
                chk32($sformatf("cont%0d_d_rdata", k), bus.d_rdata, 32'hC0DE_0000 + 32'(k));
            end else begin
                chk1 ($sformatf("cont%0d_if_done", k), bus.if_done, 1'b1);
                chk32($sformatf("cont%0d_if_rdata", k), bus.if_rdata, 32'hC0DE_0000 + 32'(k));
            end
        end
        tick();
        tick();
        chk1("cont_no_extra_grant", bus.mem_req, 1'b0);

        // Table-driven vectors
        for (int k = 0; k < NV; k++) begin
            if (tbl[k].drive_if) begin
                bus.if_addr = tbl[k].if_addr;
                bus.if_req  = 1'b1;
            end
            if (tbl[k].drive_d) begin
                bus.d_we    = tbl[k].d_we;
                bus.d_addr  = tbl[k].d_addr;
                bus.d_wdata = tbl[k].d_wdata;
                bus.d_wstrb = tbl[k].d_wstrb;
                bus.d_req   = 1'b1;
            end
            wait_grant($sformatf("v%0d_grant", k));
            chk32($sformatf("v%0d_mem_addr", k), bus.mem_addr, tbl[k].exp_addr);
            chk1 ($sformatf("v%0d_mem_we", k), bus.mem_we, tbl[k].exp_we);
            chk32($sformatf("v%0d_mem_wstrb", k), 32'(bus.mem_wstrb), 32'(tbl[k].exp_wstrb));
            if (tbl[k].exp_we) chk32($sformatf("v%0d_mem_wdata", k), bus.mem_wdata, tbl[k].exp_wdata);
            chk1($sformatf("v%0d_stall_busy", k), bus.stall, 1'b1);
            for (int h = 0; h < tbl[k].delay; h++) begin
                tick();
                chk1 ($sformatf("v%0d_hold%0d_req", k, h), bus.mem_req, 1'b1);
                chk32($sformatf("v%0d_hold%0d_addr", k, h), bus.mem_addr, tbl[k].exp_addr);
            end
            bus.mem_rdata = tbl[k].resp;
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            chk1($sformatf("v%0d_mem_req_drop", k), bus.mem_req, 1'b0);
            if (tbl[k].exp_d) begin
                chk1 ($sformatf("v%0d_d_done", k), bus.d_done, 1'b1);
                chk1 ($sformatf("v%0d_if_done_quiet", k), bus.if_done, 1'b0);
                chk32($sformatf("v%0d_d_rdata", k), bus.d_rdata, tbl[k].exp_rdata);
                bus.d_req = 1'b0;
            end else begin
                chk1 ($sformatf("v%0d_if_done", k), bus.if_done, 1'b1);
                chk1 ($sformatf("v%0d_d_done_quiet", k), bus.d_done, 1'b0);
                chk32($sformatf("v%0d_if_rdata", k), bus.if_rdata, tbl[k].exp_rdata);
                bus.if_req = 1'b0;
            end
            tick();
            nm = $sformatf("v%0d_done_one_cycle", k);
            chk1(nm, tbl[k].exp_d ? bus.d_done : bus.if_done, 1'b0);
        end
        tick();
        chk1("idle_stall_low", bus.stall, 1'b0);

        // mem_ready with no access outstanding is ignored
        bus.mem_ready = 1'b1;
        tick();
        tick();
        chk1("stray_ready_if_done", bus.if_done, 1'b0);
        chk1("stray_ready_d_done",  bus.d_done,  1'b0);
        chk1("stray_ready_mem_req", bus.mem_req, 1'b0);
        bus.mem_ready = 1'b0;

        // Reset in the middle of a data access
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h300;
        bus.d_req  = 1'b1;
        wait_grant("abort_grant");
        tick();
        rst = 1'b1;
        #1;
        chk1 ("abort_mem_req",  bus.mem_req,  1'b0);
        chk1 ("abort_d_done",   bus.d_done,   1'b0);
        chk32("abort_mem_addr", bus.mem_addr, 32'h0);
        chk32("abort_d_rdata",  bus.d_rdata,  32'h0);
        tick();
        rst = 1'b0;
        chk1("abort_no_done_after", bus.d_done, 1'b0);
        wait_grant("abort_regrant");
        chk32("abort_regrant_addr", bus.mem_addr, 32'h300);
        bus.mem_rdata = 32'h0A0B_0C0D;
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        chk1 ("abort_retry_done",  bus.d_done,  1'b1);
        chk32("abort_retry_rdata", bus.d_rdata, 32'h0A0B_0C0D);
        bus.d_req = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: memory never answers
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h400;
        bus.d_req  = 1'b1;
        wait_grant("to_grant");
        n = 0;
        while (!bus.d_done && n < 20) begin
            tick();
            n++;
        end
        chk32("to_busy_cycles", 32'(n), 32'd4);
        chk32("to_d_rdata", bus.d_rdata, 32'hFFFF_FFFF);
        chk1 ("to_bus_err", bus.bus_err, 1'b1);
        chk1 ("to_mem_req", bus.mem_req, 1'b0);
        bus.d_req = 1'b0;
        tick();
        chk1("to_bus_err_pulse", bus.bus_err, 1'b0);
        chk1("to_done_pulse",    bus.d_done,  1'b0);
`endif

        // Randomized traffic against the reference memory model
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = $urandom;
            ref_mem[i] = mem_arr[i];
        end
        model_d_rdata = 32'h0;
        fork
            fetch_thread(40);
            data_thread(40);
            responder();
        join
        for (int i = 0; i < 16; i++) chk32($sformatf("rand_mem_word%0d", i), mem_arr[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
